// File: rtl/sayeh_mem_pkg.sv
// Shared widths, FSM state type and helpers for the SAYEH paged memory controller.
`timescale 1ns/1ps
package sayeh_mem_pkg;

  localparam int TOTAL_ADDR_LEN_DEF = 16;
  localparam int PAGE_LEN_DEF       = 4;
  localparam int DATA_LEN           = 16;

  function automatic int phys_len(input int total_len, input int page_len);
    return total_len - page_len;
  endfunction

  localparam int PHYS_LEN_DEF = phys_len(TOTAL_ADDR_LEN_DEF, PAGE_LEN_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WB    = 2'd1,
    ST_FILL  = 2'd2,
    ST_SERVE = 2'd3
  } page_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/sayeh_page_ram.sv
// Single-port synchronous page buffer with one-cycle read latency (read-before-write).
`timescale 1ns/1ps
module sayeh_page_ram #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sayeh_page_controller.sv
// One-page software-visible cache in front of a word-wide backing store.
// Optional statistics counters are built only when SAYEH_PAGE_STATS_EN is defined.
`timescale 1ns/1ps
module sayeh_page_controller
  import sayeh_mem_pkg::*;
#(
  parameter int TOTAL_ADDR_LEN = TOTAL_ADDR_LEN_DEF,
  parameter int PAGE_LEN       = PAGE_LEN_DEF
) (
  input  logic                      clk,
  input  logic                      ExternalReset,
  input  logic                      ReadMem,
  input  logic                      WriteMem,
  input  logic [TOTAL_ADDR_LEN-1:0] Addressbus,
  input  logic [15:0]               DataIn,
  output logic [15:0]               DataOut,
  output logic                      MemDataready,
  output logic                      bs_req,
  output logic                      bs_we,
  output logic [TOTAL_ADDR_LEN-1:0] bs_addr,
  output logic [15:0]               bs_wdata,
  input  logic [15:0]               bs_rdata,
  input  logic                      bs_ack,
  output logic [PAGE_LEN-1:0]       cur_page,
  output logic                      page_valid,
  output logic                      dirty,
  output logic [15:0]               miss_count,
  output logic [15:0]               wb_count
);

  localparam int PHYS_LEN = phys_len(TOTAL_ADDR_LEN, PAGE_LEN);

  page_state_t         r_state, w_nextState;
  logic [PAGE_LEN-1:0] r_reqPage, r_curPage, w_reqPage, w_bsPage;
  logic [PHYS_LEN-1:0] r_offset, r_wordCnt, w_reqOffset, w_ramAddr;
  logic [15:0]         r_wdata, r_dataOut, w_ramWdata, w_ramRdata;
  logic                r_isWrite, r_armed, r_bsReq, r_pageValid, r_dirty, r_memReady;
  logic                w_request, w_hit, w_ack, w_lastWord, w_complete, w_ramWe;

  assign w_reqPage   = Addressbus[TOTAL_ADDR_LEN-1 -: PAGE_LEN];
  assign w_reqOffset = Addressbus[PHYS_LEN-1:0];
  // The completion cycle ignores requests so the CPU has one cycle to drop them.
  assign w_request   = (ReadMem | WriteMem) & ~r_memReady;
  assign w_hit       = r_pageValid && (w_reqPage == r_curPage);
  assign w_ack       = bs_ack & r_bsReq;
  assign w_lastWord  = &r_wordCnt;
  assign w_complete  = (r_state == ST_SERVE) && r_armed;

  always_ff @(posedge clk or negedge ExternalReset) begin
    if (!ExternalReset) r_state <= ST_IDLE;
    else                r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_ramAddr   = w_reqOffset;
    w_ramWe     = 1'b0;
    w_ramWdata  = r_wdata;
    case (r_state)
      ST_IDLE: begin
        if (w_request) w_nextState = w_hit ? ST_SERVE : (r_dirty ? ST_WB : ST_FILL);
      end
      ST_WB: begin
        w_ramAddr = r_wordCnt;
        if (w_ack && w_lastWord) w_nextState = ST_FILL;
      end
      ST_FILL: begin
        w_ramAddr  = r_wordCnt;
        w_ramWe    = w_ack;
        w_ramWdata = bs_rdata;
        if (w_ack && w_lastWord) w_nextState = ST_SERVE;
      end
      ST_SERVE: begin
        w_ramAddr = r_offset;
        w_ramWe   = r_armed && r_isWrite;
        if (r_armed) w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // After a fill the requested word has not been read yet, so SERVE spends one
  // unarmed cycle presenting the offset to the RAM before completing.
  always_ff @(posedge clk or negedge ExternalReset) begin
    if (!ExternalReset) begin
      r_reqPage   <= '0;
      r_offset    <= '0;
      r_isWrite   <= 1'b0;
      r_wdata     <= '0;
      r_armed     <= 1'b0;
      r_wordCnt   <= '0;
      r_bsReq     <= 1'b0;
      r_curPage   <= '0;
      r_pageValid <= 1'b0;
      r_dirty     <= 1'b0;
      r_memReady  <= 1'b0;
      r_dataOut   <= '0;
    end else begin
      r_memReady <= w_complete;
      r_dataOut  <= (w_complete && !r_isWrite) ? w_ramRdata : 16'h0000;
      case (r_state)
        ST_IDLE: begin
          if (w_request) begin
            r_reqPage <= w_reqPage;
            r_offset  <= w_reqOffset;
            r_isWrite <= WriteMem & ~ReadMem;
            r_wdata   <= DataIn;
            r_armed   <= w_hit;
            r_wordCnt <= '0;
            r_bsReq   <= !w_hit && !r_dirty;
            if (!w_hit && !r_dirty) r_pageValid <= 1'b0;
          end
        end
        ST_WB: begin
          // Request drops for a cycle after each ack while the RAM fetches the next word.
          if (w_ack) begin
            r_bsReq   <= w_lastWord;
            r_wordCnt <= w_lastWord ? '0 : r_wordCnt + 1'b1;
            if (w_lastWord) begin
              r_dirty     <= 1'b0;
              r_pageValid <= 1'b0;
            end
          end else if (!r_bsReq) begin
            r_bsReq <= 1'b1;
          end
        end
        ST_FILL: begin
          if (w_ack) begin
            r_wordCnt <= w_lastWord ? '0 : r_wordCnt + 1'b1;
            if (w_lastWord) begin
              r_bsReq     <= 1'b0;
              r_curPage   <= r_reqPage;
              r_pageValid <= 1'b1;
              r_armed     <= 1'b0;
            end
          end
        end
        ST_SERVE: begin
          if (!r_armed)        r_armed <= 1'b1;
          else if (r_isWrite)  r_dirty <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  sayeh_page_ram #(.ADDR_W(PHYS_LEN), .DATA_W(16)) u_page_ram (
    .clk     (clk),
    .i_we    (w_ramWe),
    .i_addr  (w_ramAddr),
    .i_wdata (w_ramWdata),
    .o_rdata (w_ramRdata)
  );

`ifdef SAYEH_PAGE_STATS_EN
  logic        w_missEvent;
  logic [15:0] r_missCount, r_wbCount;

  assign w_missEvent = (r_state == ST_IDLE) && w_request && !w_hit;

  always_ff @(posedge clk or negedge ExternalReset) begin
    if (!ExternalReset) begin
      r_missCount <= '0;
      r_wbCount   <= '0;
    end else if (w_missEvent) begin
      r_missCount <= sat_inc16(r_missCount);
      if (r_dirty) r_wbCount <= sat_inc16(r_wbCount);
    end
  end

  assign miss_count = r_missCount;
  assign wb_count   = r_wbCount;
`else
  assign miss_count = 16'h0000;
  assign wb_count   = 16'h0000;
`endif

  assign w_bsPage     = (r_state == ST_WB) ? r_curPage : r_reqPage;
  assign bs_req       = r_bsReq;
  assign bs_we        = r_bsReq && (r_state == ST_WB);
  assign bs_addr      = r_bsReq ? {w_bsPage, r_wordCnt} : '0;
  assign bs_wdata     = bs_we ? w_ramRdata : 16'h0000;
  assign DataOut      = r_dataOut;
  assign MemDataready = r_memReady;
  assign cur_page     = r_curPage;
  assign page_valid   = r_pageValid;
  assign dirty        = r_dirty;

endmodule

// File: tb/tb_sayeh_page_controller.sv
// Directed bench for sayeh_page_controller with a backing-store model that checks ordering and stability.
`timescale 1ns/1ps
module tb_sayeh_page_controller;

`ifdef SAYEH_PAGE_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk = 1'b0;
  logic        ExternalReset, ReadMem, WriteMem, bs_ack, MemDataready;
  logic        bs_req, bs_we, page_valid, dirty;
  logic [15:0] Addressbus, DataIn, DataOut, bs_addr, bs_wdata, bs_rdata, miss_count, wb_count;
  logic [3:0]  cur_page;

  sayeh_page_controller dut (
    .clk(clk), .ExternalReset(ExternalReset), .ReadMem(ReadMem), .WriteMem(WriteMem),
    .Addressbus(Addressbus), .DataIn(DataIn), .DataOut(DataOut), .MemDataready(MemDataready),
    .bs_req(bs_req), .bs_we(bs_we), .bs_addr(bs_addr), .bs_wdata(bs_wdata),
    .bs_rdata(bs_rdata), .bs_ack(bs_ack), .cur_page(cur_page), .page_valid(page_valid),
    .dirty(dirty), .miss_count(miss_count), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  int testsRun = 0;
  int failCount = 0;

  logic [15:0] bsMem [0:65535];
  int          maxDelay = 0;
  int          bsReads = 0, bsWrites = 0, bsReqCycles = 0, protoErr = 0, idleDataErr = 0;
  logic        pending = 1'b0, haveLast = 1'b0, lastWe = 1'b0, snapWe = 1'b0, captureFirst = 1'b0;
  logic [15:0] snapAddr = '0, snapWdata = '0, lastAddr = '0, firstAddr = '0;
  int unsigned waitLeft = 0;

  function automatic logic [15:0] bsInit(input logic [15:0] a);
    logic [15:0] t;
    t = a * 16'h9E37;
    return t ^ 16'h5A5A;
  endfunction

  // Backing-store responder: random ack delay, checks word order and request stability.
  always @(negedge clk) begin
    bs_ack = 1'b0;
    if (!ExternalReset) begin
      pending  = 1'b0;
      haveLast = 1'b0;
    end else if (bs_req) begin
      bsReqCycles++;
      if (!pending) begin
        pending   = 1'b1;
        waitLeft  = $urandom_range(maxDelay, 0);
        snapAddr  = bs_addr;
        snapWdata = bs_wdata;
        snapWe    = bs_we;
        if (captureFirst) begin
          firstAddr    = bs_addr;
          captureFirst = 1'b0;
        end
        if (bs_addr[11:0] != 12'h000) begin
          if (!haveLast || bs_addr != lastAddr + 16'd1 || bs_we != lastWe) protoErr++;
        end
      end else if (bs_addr != snapAddr || bs_wdata != snapWdata || bs_we != snapWe) begin
        protoErr++;
      end
      if (waitLeft == 0) begin
        bs_ack   = 1'b1;
        bs_rdata = bsMem[bs_addr];
        if (bs_we) begin
          bsMem[bs_addr] = bs_wdata;
          bsWrites++;
        end else begin
          bsReads++;
        end
        pending  = 1'b0;
        lastAddr = bs_addr;
        lastWe   = bs_we;
        haveLast = 1'b1;
      end else begin
        waitLeft--;
      end
    end else if (pending) begin
      protoErr++;
      pending = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr,
                               input logic [15:0] wdata, input logic [15:0] altAddr, input int bound,
                               output logic [15:0] data, output int cycles, output logic done);
    @(negedge clk);
    ReadMem = rd; WriteMem = wr; Addressbus = addr; DataIn = wdata;
    cycles = 0; done = 1'b0; data = '0;
    while (!done && cycles < bound) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) Addressbus = altAddr;
      if (MemDataready) begin
        done = 1'b1;
        data = DataOut;
      end else if (DataOut != 16'h0000) begin
        idleDataErr++;
      end
    end
    ReadMem = 1'b0; WriteMem = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] expData;
    logic        expDirty;
  } vec_t;

  vec_t        vecs[8];
  logic [15:0] rdData;
  int          cyc, reads0, writes0, reqs0;
  logic        done;

  initial begin
    for (int i = 0; i < 65536; i++) bsMem[i] = bsInit(i[15:0]);
    vecs[0] = '{1'b1, 1'b1, 16'h3020, 16'hDEAD, bsInit(16'h3020), 1'b0};
    vecs[1] = '{1'b1, 1'b0, 16'h3020, 16'h0000, bsInit(16'h3020), 1'b0};
    vecs[2] = '{1'b0, 1'b1, 16'h3010, 16'hBEEF, 16'h0000,         1'b1};
    vecs[3] = '{1'b1, 1'b0, 16'h3010, 16'h0000, 16'hBEEF,         1'b1};
    vecs[4] = '{1'b1, 1'b0, 16'h3005, 16'h0000, bsInit(16'h3005), 1'b1};
    vecs[5] = '{1'b0, 1'b1, 16'h3FFF, 16'h1234, 16'h0000,         1'b1};
    vecs[6] = '{1'b1, 1'b0, 16'h3FFF, 16'h0000, 16'h1234,         1'b1};
    vecs[7] = '{1'b1, 1'b0, 16'h3000, 16'h0000, bsInit(16'h3000), 1'b1};

    ExternalReset = 1'b0; ReadMem = 1'b0; WriteMem = 1'b0;
    Addressbus = '0; DataIn = '0; bs_ack = 1'b0; bs_rdata = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst MemDataready", {31'd0, MemDataready}, 32'd0);
    checkOutput("rst bs_req", {31'd0, bs_req}, 32'd0);
    checkOutput("rst bs_we", {31'd0, bs_we}, 32'd0);
    checkOutput("rst bs_addr", {16'd0, bs_addr}, 32'd0);
    checkOutput("rst bs_wdata", {16'd0, bs_wdata}, 32'd0);
    checkOutput("rst DataOut", {16'd0, DataOut}, 32'd0);
    checkOutput("rst cur_page", {28'd0, cur_page}, 32'd0);
    checkOutput("rst page_valid", {31'd0, page_valid}, 32'd0);
    checkOutput("rst dirty", {31'd0, dirty}, 32'd0);
    checkOutput("rst miss_count", {16'd0, miss_count}, 32'd0);
    checkOutput("rst wb_count", {16'd0, wb_count}, 32'd0);
    ExternalReset = 1'b1;

    // Cold miss on page 3; the address bus is scrambled once the request is taken.
    reads0 = bsReads; writes0 = bsWrites;
    applyStimulus(1'b1, 1'b0, 16'h3005, 16'h0000, 16'hF0FF, 20000, rdData, cyc, done);
    checkOutput("fill3 done", {31'd0, done}, 32'd1);
    checkOutput("fill3 data", {16'd0, rdData}, {16'd0, bsInit(16'h3005)});
    checkOutput("fill3 reads", bsReads - reads0, 32'd4096);
    checkOutput("fill3 writes", bsWrites - writes0, 32'd0);
    checkOutput("fill3 miss_count", {16'd0, miss_count}, STATS);
    checkOutput("fill3 cur_page", {28'd0, cur_page}, 32'd3);
    checkOutput("fill3 page_valid", {31'd0, page_valid}, 32'd1);
    checkOutput("fill3 dirty", {31'd0, dirty}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      reqs0 = bsReqCycles;
      applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].addr, 20, rdData, cyc, done);
      checkOutput($sformatf("vec%0d data", i), {16'd0, rdData}, {16'd0, vecs[i].expData});
      checkOutput($sformatf("vec%0d latency", i), cyc, 32'd2);
      checkOutput($sformatf("vec%0d bs_req cycles", i), bsReqCycles - reqs0, 32'd0);
      checkOutput($sformatf("vec%0d dirty", i), {31'd0, dirty}, {31'd0, vecs[i].expDirty});
    end

    // Dirty miss to page 7 with a slow, randomly delayed backing store.
    maxDelay = 5;
    reads0 = bsReads; writes0 = bsWrites;
    applyStimulus(1'b1, 1'b0, 16'h7000, 16'h0000, 16'h7000, 60000, rdData, cyc, done);
    checkOutput("wb7 done", {31'd0, done}, 32'd1);
    checkOutput("wb7 data", {16'd0, rdData}, {16'd0, bsInit(16'h7000)});
    checkOutput("wb7 writes", bsWrites - writes0, 32'd4096);
    checkOutput("wb7 reads", bsReads - reads0, 32'd4096);
    checkOutput("wb7 bs 3010", {16'd0, bsMem[16'h3010]}, 32'h0000BEEF);
    checkOutput("wb7 bs 3FFF", {16'd0, bsMem[16'h3FFF]}, 32'h00001234);
    checkOutput("wb7 bs 3020", {16'd0, bsMem[16'h3020]}, {16'd0, bsInit(16'h3020)});
    checkOutput("wb7 bs 3005", {16'd0, bsMem[16'h3005]}, {16'd0, bsInit(16'h3005)});
    checkOutput("wb7 wb_count", {16'd0, wb_count}, STATS);
    checkOutput("wb7 miss_count", {16'd0, miss_count}, 2 * STATS);
    checkOutput("wb7 cur_page", {28'd0, cur_page}, 32'd7);
    checkOutput("wb7 dirty", {31'd0, dirty}, 32'd0);
    checkOutput("wb7 protocol errors", protoErr, 32'd0);
    maxDelay = 0;

    // Reset in the middle of a fill, then the same page restarts from offset 0.
    @(negedge clk);
    ReadMem = 1'b1; Addressbus = 16'h9000;
    repeat (100) @(negedge clk);
    ExternalReset = 1'b0;
    #1;
    checkOutput("midrst bs_req", {31'd0, bs_req}, 32'd0);
    checkOutput("midrst page_valid", {31'd0, page_valid}, 32'd0);
    checkOutput("midrst miss_count", {16'd0, miss_count}, 32'd0);
    ReadMem = 1'b0;
    @(negedge clk);
    ExternalReset = 1'b1;
    captureFirst = 1'b1;
    reads0 = bsReads;
    applyStimulus(1'b1, 1'b0, 16'h9123, 16'h0000, 16'h9123, 20000, rdData, cyc, done);
    checkOutput("refill first addr", {16'd0, firstAddr}, 32'h00009000);
    checkOutput("refill data", {16'd0, rdData}, {16'd0, bsInit(16'h9123)});
    checkOutput("refill reads", bsReads - reads0, 32'd4096);
    checkOutput("refill cur_page", {28'd0, cur_page}, 32'd9);
    checkOutput("refill miss_count", {16'd0, miss_count}, STATS);
    checkOutput("final protocol errors", protoErr, 32'd0);
    checkOutput("DataOut nonzero while not ready", idleDataErr, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
